smc_pwm_core: RTL and testbench
===============================

Name: smc_pwm_core

Overview:
Parametrised stepper-motor-controller PWM core. It replaces the fixed-pattern SMC output with a programmable period counter and NCH independent PWM channels. Each channel supports left-, right- or center-aligned modes and a sign bit that steers the pulse onto MNP or MNM. It sits behind the Q-bus register interface and drives the coil pins MNM/MNP directly.

Parameters:
NCH, 12, number of PWM channels (1..16)
CNT_W, 11, period counter and duty magnitude width (4..15)
DW, 16, Q-bus data width

Ports:
QCLK  input  1  core clock
QRESET  input  1  synchronous, active-high reset
QWRITE  input  1  1 = write, 0 = read (qualified by QSEL)
QSEL  input  1  bus access strobe, one cycle per access
QADDR  input  7  word register address
QDATAIN  input  DW  write data
QDATAOUT  output  DW  read data, registered
MNM  output  NCH  minus-side coil drive
MNP  output  NCH  plus-side coil drive

Behaviour:
- One clock (QCLK). Reset is synchronous and active-high (QRESET): on a QCLK edge with QRESET=1, all registers, shadows, prescaler, counter, QDATAOUT, MNM and MNP become 0. QRESET overrides any bus access in the same cycle.
- Register map (word addresses). Unmapped addresses: writes ignored, reads return 0.
  - 0x00 CTL0: [0] EN; [2:1] PRE (tick every 1/2/4/8 QCLKs).
  - 0x01 CTL1: [0] PF, period flag, write-1-to-clear.
  - 0x02 PER: [CNT_W-1:0], buffered.
  - 0x10+i CCi, i<NCH: [1:0] MODE (00 off, 01 left, 10 right, 11 center).
  - 0x20+i DCi, i<NCH: [15] S, [CNT_W-1:0] DUTY, buffered.
- Write: QSEL&QWRITE latches QDATAIN on that edge. Unused bits read back as 0.
- Read: QSEL&!QWRITE. QDATAOUT holds the addressed value one cycle later and keeps it until the next read. PER and DC reads return shadow values.
- Buffering: PER and DCi writes go to shadow registers. Shadows copy to active registers:
  - on each period wrap, or
  - every cycle while EN=0.
  CTL and CC writes take effect immediately.
- Counter:
  - EN=0: prescaler and counter held at 0.
  - EN=1: counter advances on each prescaler tick through 0..PER_act-1, then wraps to 0.
  - A wrap sets PF and loads the shadows.
  - PER_act=0: counter stays 0, all channel outputs inactive, PF never set.
  - A PF set and a W1C in the same cycle: set wins.
- Channel active condition (cnt = counter, P = PER_act, D = min(DUTY_act, P)):
  - left: cnt < D
  - right: cnt >= P-D
  - center: with L=(P-D)>>1, L <= cnt < L+D
  - off, or D=0: never active. D>=P: always active while P>0.
- Steering:
  - S=0: MNP[i] = active, MNM[i] = 0.
  - S=1: MNM[i] = active, MNP[i] = 0.
  - MNM[i] and MNP[i] are never both 1.
- Timing:
  - Outputs are registered: pins reflect the counter value one QCLK after it.
  - Clearing EN forces all outputs to 0 on the next edge.
  - Setting EN starts counting from 0 with freshly loaded shadows.

Test Plan:
1. Reset, then read every mapped address -> QDATAOUT=0, MNM=MNP=0. Write during QRESET=1 -> ignored.
2. PER=4, CC4=01, DC4=0x0003, CTL0=0x01 -> MNP[4] repeats 1,1,1,0 with period 4 QCLKs. MNM all 0; other channels 0; PF set after the first wrap.
3. Same setup, then DC4=0x8002 mid-period -> pattern unchanged until the wrap. Afterwards MNM[4] repeats 1,1,0,0 and MNP[4]=0.
4. PER=8, DC1=4: CC1=10 -> MNP[1] high on counts 4..7. CC1=11 -> high on counts 2..5. PRE=01 -> every level lasts 2 QCLKs.
5. Boundaries: DC=0 -> constant 0. DC=0x7FF with PER=8 -> constant 1. PER=0 with EN=1 -> outputs 0, PF stays 0.
6. CTL1 W1C in the same cycle as a wrap -> PF reads 1. Clear EN mid-period -> outputs 0 next cycle, counter reads from 0 on re-enable. Read of 0x7F -> 0.

Source files
------------

// File: rtl/smc_pwm_core.sv
// smc_pwm_core: programmable period counter driving NCH independent PWM
// channels (left/right/center aligned) onto MNP/MNM coil pins, with a
// Q-bus register file and period-boundary buffering of PER and duty.
module smc_pwm_core #(
    parameter int unsigned NCH   = 12,
    parameter int unsigned CNT_W = 11,
    parameter int unsigned DW    = 16
) (
    input  logic             QCLK,
    input  logic             QRESET,
    input  logic             QWRITE,
    input  logic             QSEL,
    input  logic [6:0]       QADDR,
    input  logic [DW-1:0]    QDATAIN,
    output logic [DW-1:0]    QDATAOUT,
    output logic [NCH-1:0]   MNM,
    output logic [NCH-1:0]   MNP
);

    localparam int unsigned AW    = 7;
    localparam int unsigned PS_W  = 3;
    localparam int unsigned S_BIT = 15;

    localparam logic [AW-1:0] A_CTL0 = 7'h00;
    localparam logic [AW-1:0] A_CTL1 = 7'h01;
    localparam logic [AW-1:0] A_PER  = 7'h02;

    logic                         en_q, en_d;
    logic [1:0]                   pre_q, pre_d;
    logic                         pf_q, pf_d;
    logic [CNT_W-1:0]             per_sh_q, per_sh_d;
    logic [CNT_W-1:0]             per_act_q, per_act_d;
    logic [PS_W-1:0]              presc_q, presc_d;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic [NCH-1:0][1:0]          mode_q, mode_d;
    logic [NCH-1:0][CNT_W-1:0]    duty_sh_q, duty_sh_d;
    logic [NCH-1:0][CNT_W-1:0]    duty_act_q, duty_act_d;
    logic [NCH-1:0]               s_sh_q, s_sh_d;
    logic [NCH-1:0]               s_act_q, s_act_d;
    logic [DW-1:0]                qdout_q, qdout_d;
    logic [NCH-1:0]               mnm_q, mnm_d;
    logic [NCH-1:0]               mnp_q, mnp_d;

    logic                         wr_c, rd_c, tick_c, wrap_c;
    logic [PS_W-1:0]              presc_max_c;
    logic [DW-1:0]                rdata_c;
    logic [NCH-1:0]               act_c;
    logic                         unused_bits;

    // Bits of QDATAIN above the duty field and below S are don't-care.
    assign unused_bits = ^QDATAIN;

    // Channel active test; duty is clamped to the period first.
    function automatic logic chan_active(input logic [1:0] mode,
                                         input logic [CNT_W-1:0] duty,
                                         input logic [CNT_W-1:0] per,
                                         input logic [CNT_W-1:0] cnt);
        logic [CNT_W-1:0] d;
        logic [CNT_W-1:0] lo;
        logic             act;
        d   = (duty < per) ? duty : per;
        lo  = (per - d) >> 1;
        act = 1'b0;
        if (mode != 2'b00 && per != '0 && d != '0) begin
            if (d == per) begin
                act = 1'b1;
            end else begin
                case (mode)
                    2'b01:   act = (cnt < d);
                    2'b10:   act = (cnt >= per - d);
                    default: act = (cnt >= lo) && (cnt < lo + d);
                endcase
            end
        end
        return act;
    endfunction

    // Bus decode, read mux, prescaler/counter, buffering and pin drive.
    always_comb begin
        en_d        = en_q;
        pre_d       = pre_q;
        pf_d        = pf_q;
        per_sh_d    = per_sh_q;
        per_act_d   = per_act_q;
        presc_d     = presc_q;
        cnt_d       = cnt_q;
        mode_d      = mode_q;
        duty_sh_d   = duty_sh_q;
        duty_act_d  = duty_act_q;
        s_sh_d      = s_sh_q;
        s_act_d     = s_act_q;
        qdout_d     = qdout_q;
        mnm_d       = '0;
        mnp_d       = '0;
        act_c       = '0;
        rdata_c     = '0;
        wrap_c      = 1'b0;
        wr_c        = QSEL & QWRITE;
        rd_c        = QSEL & ~QWRITE;
        presc_max_c = PS_W'((32'd1 << pre_q) - 32'd1);
        tick_c      = (presc_q >= presc_max_c);

        case (QADDR)
            A_CTL0:  rdata_c[2:0] = {pre_q, en_q};
            A_CTL1:  rdata_c[0] = pf_q;
            A_PER:   rdata_c[CNT_W-1:0] = per_sh_q;
            default: ;
        endcase
        for (int i = 0; i < NCH; i++) begin
            if (QADDR == AW'(16 + i)) rdata_c[1:0] = mode_q[i];
            if (QADDR == AW'(32 + i)) begin
                rdata_c[S_BIT]      = s_sh_q[i];
                rdata_c[CNT_W-1:0]  = duty_sh_q[i];
            end
        end
        if (rd_c) qdout_d = rdata_c;

        if (!en_q) begin
            presc_d = '0;
            cnt_d   = '0;
        end else if (tick_c) begin
            presc_d = '0;
            if (per_act_q != '0) begin
                if (cnt_q >= per_act_q - CNT_W'(1)) begin
                    cnt_d  = '0;
                    wrap_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
        end else begin
            presc_d = presc_q + PS_W'(1);
        end

        if (wrap_c || !en_q) begin
            per_act_d  = per_sh_q;
            duty_act_d = duty_sh_q;
            s_act_d    = s_sh_q;
        end

        for (int i = 0; i < NCH; i++) begin
            act_c[i] = en_q & chan_active(mode_q[i], duty_act_q[i], per_act_q, cnt_q);
            mnp_d[i] = act_c[i] & ~s_act_q[i];
            mnm_d[i] = act_c[i] &  s_act_q[i];
        end

        if (wr_c) begin
            case (QADDR)
                A_CTL0: begin
                    en_d  = QDATAIN[0];
                    pre_d = QDATAIN[2:1];
                end
                A_CTL1:  if (QDATAIN[0]) pf_d = 1'b0;
                A_PER:   per_sh_d = QDATAIN[CNT_W-1:0];
                default: ;
            endcase
            for (int i = 0; i < NCH; i++) begin
                if (QADDR == AW'(16 + i)) mode_d[i] = QDATAIN[1:0];
                if (QADDR == AW'(32 + i)) begin
                    s_sh_d[i]    = QDATAIN[S_BIT];
                    duty_sh_d[i] = QDATAIN[CNT_W-1:0];
                end
            end
        end
        // A wrap in the same cycle as a W1C keeps the flag set.
        if (wrap_c) pf_d = 1'b1;
    end

    // State registers with synchronous reset.
    always_ff @(posedge QCLK) begin
        if (QRESET) begin
            en_q       <= 1'b0;
            pre_q      <= '0;
            pf_q       <= 1'b0;
            per_sh_q   <= '0;
            per_act_q  <= '0;
            presc_q    <= '0;
            cnt_q      <= '0;
            mode_q     <= '0;
            duty_sh_q  <= '0;
            duty_act_q <= '0;
            s_sh_q     <= '0;
            s_act_q    <= '0;
            qdout_q    <= '0;
            mnm_q      <= '0;
            mnp_q      <= '0;
        end else begin
            en_q       <= en_d;
            pre_q      <= pre_d;
            pf_q       <= pf_d;
            per_sh_q   <= per_sh_d;
            per_act_q  <= per_act_d;
            presc_q    <= presc_d;
            cnt_q      <= cnt_d;
            mode_q     <= mode_d;
            duty_sh_q  <= duty_sh_d;
            duty_act_q <= duty_act_d;
            s_sh_q     <= s_sh_d;
            s_act_q    <= s_act_d;
            qdout_q    <= qdout_d;
            mnm_q      <= mnm_d;
            mnp_q      <= mnp_d;
        end
    end

    assign QDATAOUT = qdout_q;
    assign MNM      = mnm_q;
    assign MNP      = mnp_q;

endmodule

// File: tb/tb_smc_pwm_core.sv
// Testbench for smc_pwm_core: directed scenarios plus randomized bus traffic
// checked against a cycle-level behavioural model of the PWM rules.
module tb_smc_pwm_core;

    localparam int NCH   = 12;
    localparam int CNT_W = 11;
    localparam int DW    = 16;
    localparam int CMASK = (1 << CNT_W) - 1;

    logic            QCLK, QRESET, QWRITE, QSEL;
    logic [6:0]      QADDR;
    logic [DW-1:0]   QDATAIN, QDATAOUT;
    logic [NCH-1:0]  MNM, MNP;

    int vectors = 0;
    int miscompares = 0;

    smc_pwm_core #(.NCH(NCH), .CNT_W(CNT_W), .DW(DW)) dut (
        .QCLK(QCLK), .QRESET(QRESET), .QWRITE(QWRITE), .QSEL(QSEL),
        .QADDR(QADDR), .QDATAIN(QDATAIN), .QDATAOUT(QDATAOUT),
        .MNM(MNM), .MNP(MNP)
    );

    initial QCLK = 1'b0;
    always #5 QCLK = ~QCLK;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Behavioural model state (what the registers should hold after each edge).
    int m_en, m_pre, m_pf, m_per_sh, m_per_act, m_cnt, m_div, m_qout;
    int m_mode[NCH], m_duty_sh[NCH], m_s_sh[NCH], m_duty_act[NCH], m_s_act[NCH];
    logic [NCH-1:0] m_mnp, m_mnm;

    function automatic bit chan_on(int i);
        int p, d, lo;
        p = m_per_act;
        d = (m_duty_act[i] < p) ? m_duty_act[i] : p;
        if (m_mode[i] == 0 || p == 0 || d == 0) return 1'b0;
        if (d >= p) return 1'b1;
        if (m_mode[i] == 1) return m_cnt < d;
        if (m_mode[i] == 2) return m_cnt >= p - d;
        lo = (p - d) / 2;
        return (m_cnt >= lo) && (m_cnt < lo + d);
    endfunction

    function automatic int rd_val(int addr);
        if (addr == 0) return m_pre * 2 + m_en;
        if (addr == 1) return m_pf;
        if (addr == 2) return m_per_sh;
        if (addr >= 16 && addr < 16 + NCH) return m_mode[addr-16];
        if (addr >= 32 && addr < 32 + NCH) return m_s_sh[addr-32] * 32768 + m_duty_sh[addr-32];
        return 0;
    endfunction

    task automatic model_step(input bit rst, input bit sel, input bit wr, input int addr, input int din);
        logic [NCH-1:0] nmnp, nmnm;
        bit wrap;
        nmnp = '0;
        nmnm = '0;
        wrap = 1'b0;
        if (rst) begin
            m_en = 0; m_pre = 0; m_pf = 0; m_per_sh = 0; m_per_act = 0;
            m_cnt = 0; m_div = 0; m_qout = 0; m_mnp = '0; m_mnm = '0;
            for (int i = 0; i < NCH; i++) begin
                m_mode[i] = 0; m_duty_sh[i] = 0; m_s_sh[i] = 0;
                m_duty_act[i] = 0; m_s_act[i] = 0;
            end
            return;
        end
        for (int i = 0; i < NCH; i++)
            if (m_en != 0 && chan_on(i)) begin
                if (m_s_act[i] != 0) nmnm[i] = 1'b1;
                else nmnp[i] = 1'b1;
            end
        if (sel && !wr) m_qout = rd_val(addr);
        if (m_en == 0) begin
            m_div = 0;
            m_cnt = 0;
        end else begin
            m_div++;
            if (m_div >= (1 << m_pre)) begin
                m_div = 0;
                if (m_per_act > 0) begin
                    m_cnt++;
                    if (m_cnt >= m_per_act) begin
                        m_cnt = 0;
                        wrap = 1'b1;
                    end
                end
            end
        end
        if (wrap || m_en == 0) begin
            m_per_act = m_per_sh;
            for (int i = 0; i < NCH; i++) begin
                m_duty_act[i] = m_duty_sh[i];
                m_s_act[i] = m_s_sh[i];
            end
        end
        if (sel && wr) begin
            if (addr == 0) begin
                m_en = din & 1;
                m_pre = (din >> 1) & 3;
            end else if (addr == 1) begin
                if ((din & 1) != 0) m_pf = 0;
            end else if (addr == 2) begin
                m_per_sh = din & CMASK;
            end else if (addr >= 16 && addr < 16 + NCH) begin
                m_mode[addr-16] = din & 3;
            end else if (addr >= 32 && addr < 32 + NCH) begin
                m_duty_sh[addr-32] = din & CMASK;
                m_s_sh[addr-32] = (din >> 15) & 1;
            end
        end
        if (wrap) m_pf = 1;
        m_mnp = nmnp;
        m_mnm = nmnm;
    endtask

    // One bus cycle: drive, advance model, clock, settle.
    task automatic op(input bit rst, input bit sel, input bit wr, input int addr, input int din);
        QRESET  = rst;
        QSEL    = sel;
        QWRITE  = wr;
        QADDR   = 7'(addr);
        QDATAIN = 16'(din);
        model_step(rst, sel, wr, addr, din);
        @(posedge QCLK);
        #1;
        QRESET = 1'b0;
        QSEL   = 1'b0;
        QWRITE = 1'b0;
    endtask

    task automatic wr_reg(input int addr, input int din);
        op(1'b0, 1'b1, 1'b1, addr, din);
    endtask

    task automatic rd_reg(input int addr);
        op(1'b0, 1'b1, 1'b0, addr, 0);
    endtask

    task automatic idle();
        op(1'b0, 1'b0, 1'b0, 0, 0);
    endtask

    task automatic test_reset();
        int addrs[$];
        op(1'b1, 1'b1, 1'b1, 0, 16'h0007);
        op(1'b1, 1'b1, 1'b1, 32'h24, 16'h0005);
        vectors++;
        if (MNP !== '0 || MNM !== '0 || QDATAOUT !== '0) begin
            miscompares++;
            $display("FAIL reset_state: MNP=%h MNM=%h QDATAOUT=%h, want all 0", MNP, MNM, QDATAOUT);
        end
        addrs = {0, 1, 2};
        for (int i = 0; i < NCH; i++) addrs.push_back(16 + i);
        for (int i = 0; i < NCH; i++) addrs.push_back(32 + i);
        foreach (addrs[k]) begin
            rd_reg(addrs[k]);
            vectors++;
            if (QDATAOUT !== 16'h0000 || MNP !== '0 || MNM !== '0) begin
                miscompares++;
                $display("FAIL reset_read addr %h: QDATAOUT=%h MNP=%h MNM=%h, want 0", addrs[k], QDATAOUT, MNP, MNM);
            end
        end
    endtask

    task automatic test_left();
        logic [NCH-1:0] exp_p;
        wr_reg(2, 4);
        wr_reg(32'h14, 1);
        wr_reg(32'h24, 3);
        wr_reg(0, 1);
        for (int k = 1; k <= 12; k++) begin
            idle();
            exp_p = (((k - 1) % 4) < 3) ? NCH'(1 << 4) : '0;
            vectors++;
            if (MNP !== exp_p || MNM !== '0 || MNP !== m_mnp) begin
                miscompares++;
                $display("FAIL left_pattern k=%0d: MNP=%h MNM=%h, want MNP=%h MNM=0", k, MNP, MNM, exp_p);
            end
        end
        rd_reg(1);
        vectors++;
        if (QDATAOUT !== 16'h0001) begin
            miscompares++;
            $display("FAIL left_pf: CTL1=%h, want 0001", QDATAOUT);
        end
    endtask

    task automatic test_buffered();
        int n, ones;
        n = 0;
        while (m_cnt != 1 && n < 20) begin
            idle();
            n++;
        end
        vectors++;
        if (m_cnt != 1) begin
            miscompares++;
            $display("FAIL buffered_sync: counter phase not reached, cnt=%0d want 1", m_cnt);
        end
        wr_reg(32'h24, 16'h8002);
        vectors++;
        if (MNP !== m_mnp || MNM !== '0) begin
            miscompares++;
            $display("FAIL buffered_hold: MNP=%h MNM=%h, want MNP=%h MNM=0", MNP, MNM, m_mnp);
        end
        for (int k = 0; k < 4; k++) begin
            idle();
            vectors++;
            if (MNP !== m_mnp || MNM !== m_mnm) begin
                miscompares++;
                $display("FAIL buffered_edge k=%0d: MNP=%h MNM=%h, want MNP=%h MNM=%h", k, MNP, MNM, m_mnp, m_mnm);
            end
        end
        ones = 0;
        for (int k = 0; k < 8; k++) begin
            idle();
            ones += int'(MNM[4]);
            vectors++;
            if (MNP !== '0 || MNM !== m_mnm || (MNM & ~NCH'(1 << 4)) !== '0) begin
                miscompares++;
                $display("FAIL buffered_neg k=%0d: MNP=%h MNM=%h, want MNP=0 MNM=%h", k, MNP, MNM, m_mnm);
            end
        end
        vectors++;
        if (ones != 4) begin
            miscompares++;
            $display("FAIL buffered_duty: MNM[4] high %0d of 8 cycles, want 4", ones);
        end
    endtask

    task automatic test_modes();
        logic e;
        int c;
        wr_reg(0, 0);
        wr_reg(32'h14, 0);
        wr_reg(2, 8);
        wr_reg(32'h21, 4);
        wr_reg(32'h11, 2);
        wr_reg(0, 1);
        for (int k = 1; k <= 16; k++) begin
            idle();
            e = (((k - 1) % 8) >= 4);
            vectors++;
            if (MNP !== NCH'(32'(e) << 1) || MNM !== '0) begin
                miscompares++;
                $display("FAIL right_mode k=%0d: MNP=%h MNM=%h, want MNP[1]=%0d only", k, MNP, MNM, e);
            end
        end
        wr_reg(0, 0);
        wr_reg(32'h11, 3);
        wr_reg(0, 1);
        for (int k = 1; k <= 16; k++) begin
            idle();
            c = (k - 1) % 8;
            e = (c >= 2 && c <= 5);
            vectors++;
            if (MNP !== NCH'(32'(e) << 1) || MNM !== '0) begin
                miscompares++;
                $display("FAIL center_mode k=%0d: MNP=%h MNM=%h, want MNP[1]=%0d only", k, MNP, MNM, e);
            end
        end
        wr_reg(0, 0);
        wr_reg(0, 3);
        for (int k = 1; k <= 32; k++) begin
            idle();
            c = ((k - 1) / 2) % 8;
            e = (c >= 2 && c <= 5);
            vectors++;
            if (MNP !== NCH'(32'(e) << 1) || MNP !== m_mnp) begin
                miscompares++;
                $display("FAIL prescale k=%0d: MNP=%h, want MNP[1]=%0d only", k, MNP, e);
            end
        end
    endtask

    task automatic test_bounds();
        wr_reg(0, 0);
        wr_reg(32'h11, 1);
        wr_reg(32'h21, 0);
        wr_reg(0, 1);
        for (int k = 0; k < 10; k++) begin
            idle();
            vectors++;
            if (MNP !== '0 || MNM !== '0) begin
                miscompares++;
                $display("FAIL duty_zero k=%0d: MNP=%h MNM=%h, want 0", k, MNP, MNM);
            end
        end
        wr_reg(0, 0);
        wr_reg(32'h21, 16'h07FF);
        wr_reg(0, 1);
        for (int k = 0; k < 10; k++) begin
            idle();
            vectors++;
            if (MNP !== NCH'(2) || MNM !== '0) begin
                miscompares++;
                $display("FAIL duty_full k=%0d: MNP=%h MNM=%h, want MNP=002", k, MNP, MNM);
            end
        end
        wr_reg(0, 0);
        wr_reg(2, 0);
        wr_reg(1, 1);
        wr_reg(0, 1);
        for (int k = 0; k < 10; k++) begin
            idle();
            vectors++;
            if (MNP !== '0 || MNM !== '0) begin
                miscompares++;
                $display("FAIL per_zero k=%0d: MNP=%h MNM=%h, want 0", k, MNP, MNM);
            end
        end
        rd_reg(1);
        vectors++;
        if (QDATAOUT !== 16'h0000) begin
            miscompares++;
            $display("FAIL per_zero_pf: CTL1=%h, want 0000", QDATAOUT);
        end
    endtask

    task automatic test_w1c_wrap();
        int n;
        logic [NCH-1:0] exp_p;
        wr_reg(0, 0);
        wr_reg(32'h11, 0);
        wr_reg(2, 4);
        wr_reg(32'h14, 1);
        wr_reg(32'h24, 3);
        wr_reg(1, 1);
        wr_reg(0, 1);
        n = 0;
        while (m_cnt != 3 && n < 20) begin
            idle();
            n++;
        end
        wr_reg(1, 1);
        rd_reg(1);
        vectors++;
        if (QDATAOUT !== 16'h0001) begin
            miscompares++;
            $display("FAIL w1c_vs_wrap: CTL1=%h, want 0001", QDATAOUT);
        end
        n = 0;
        while (m_cnt != 1 && n < 20) begin
            idle();
            n++;
        end
        wr_reg(0, 0);
        idle();
        vectors++;
        if (MNP !== '0 || MNM !== '0) begin
            miscompares++;
            $display("FAIL en_clear: MNP=%h MNM=%h, want 0", MNP, MNM);
        end
        wr_reg(0, 1);
        for (int k = 1; k <= 8; k++) begin
            idle();
            exp_p = (((k - 1) % 4) < 3) ? NCH'(1 << 4) : '0;
            vectors++;
            if (MNP !== exp_p || MNM !== '0) begin
                miscompares++;
                $display("FAIL reenable k=%0d: MNP=%h MNM=%h, want MNP=%h", k, MNP, MNM, exp_p);
            end
        end
        rd_reg(0);
        rd_reg(32'h7F);
        vectors++;
        if (QDATAOUT !== 16'h0000) begin
            miscompares++;
            $display("FAIL unmapped_read: QDATAOUT=%h, want 0000", QDATAOUT);
        end
    endtask

    task automatic test_random();
        int r, a, d;
        for (int k = 0; k < 800; k++) begin
            r = $urandom_range(0, 99);
            if (r < 55) begin
                idle();
            end else if (r < 65) begin
                a = $urandom_range(0, 3);
                if (a == 3) a = $urandom_range(0, 127);
                else if (a == 1) a = 16 + $urandom_range(0, 15);
                else if (a == 2) a = 32 + $urandom_range(0, 15);
                rd_reg(a);
            end else begin
                a = $urandom_range(0, 5);
                if (a == 0) begin
                    d = ($urandom_range(0, 9) != 0) ? 1 : 0;
                    d = d | ($urandom_range(0, 3) << 1) | ($urandom & 32'hFFF8);
                    wr_reg(0, d);
                end else if (a == 1) begin
                    wr_reg(1, $urandom & 32'hFFFF);
                end else if (a == 2) begin
                    wr_reg(2, $urandom_range(0, 10) | (($urandom & 1) << 12));
                end else if (a == 3) begin
                    wr_reg(16 + $urandom_range(0, 15), $urandom & 32'hFFFF);
                end else begin
                    d = $urandom_range(0, 12) | ($urandom & 32'h8000);
                    if ($urandom_range(0, 7) == 0) d = d | ($urandom & 32'h7800);
                    wr_reg(32 + $urandom_range(0, 15), d);
                end
            end
            vectors++;
            if (MNP !== m_mnp) begin
                miscompares++;
                $display("FAIL rand_mnp cyc %0d: MNP=%h, want %h", k, MNP, m_mnp);
            end
            vectors++;
            if (MNM !== m_mnm) begin
                miscompares++;
                $display("FAIL rand_mnm cyc %0d: MNM=%h, want %h", k, MNM, m_mnm);
            end
            vectors++;
            if (QDATAOUT !== 16'(m_qout)) begin
                miscompares++;
                $display("FAIL rand_qdata cyc %0d: QDATAOUT=%h, want %h", k, QDATAOUT, 16'(m_qout));
            end
        end
    endtask

    initial begin
        QRESET  = 1'b1;
        QSEL    = 1'b0;
        QWRITE  = 1'b0;
        QADDR   = '0;
        QDATAIN = '0;
        test_reset();
        test_left();
        test_buffered();
        test_modes();
        test_bounds();
        test_w1c_wrap();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
